bit_serial_adder: RTL and testbench

//   Sequential N-bit adder built around one instance of the existing 1-bit full adder (fa).

---
 rtl/bit_serial_adder_pkg.sv | 21 ++
 rtl/bit_serial_adder_fa.sv | 22 ++
 rtl/bit_serial_adder.sv | 163 ++++++++++++++++
 tb/tb_bit_serial_adder.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bit_serial_adder_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : bit_serial_adder_pkg                                           |
// | Brief   : State encodings and width helper shared by the serial adder.   |
// | Rev     : 1.0                                                            |
// +--------------------------------------------------------------------------+
package bit_serial_adder_pkg;

    typedef enum logic [1:0] {
        BSA_IDLE = 2'd0,
        BSA_RUN  = 2'd1,
        BSA_DONE = 2'd2
    } bsa_state_e;

    // Bit counter must be able to hold N, the value it steps to on the last RUN cycle
    function automatic int bsa_cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage : bit_serial_adder_pkg
`default_nettype wire

// File: rtl/bit_serial_adder_fa.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : fa                                                             |
// | Brief   : 1-bit full adder used as the serial adder's arithmetic core.   |
// | Rev     : 1.0                                                            |
// +--------------------------------------------------------------------------+
module fa (
    output logic co,
    output logic s,
    input  logic ci,
    input  logic x,
    input  logic y
);

    logic p;

    assign p  = x ^ y;
    assign s  = p ^ ci;
    assign co = (x & y) | (ci & p);

endmodule : fa
`default_nettype wire

// File: rtl/bit_serial_adder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : bit_serial_adder                                               |
// | Brief   : N-bit adder evaluated LSB-first, one bit per clock, through a  |
// |           single full adder with start/busy/done handshake.              |
// |           Define BSA_OVERFLOW_EN to add the signed-overflow output ov.   |
// | Rev     : 1.0                                                            |
// +--------------------------------------------------------------------------+
module bit_serial_adder
    import bit_serial_adder_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         ci,
    output logic [N-1:0] r,
    output logic         co,
    output logic         busy,
    output logic         done
`ifdef BSA_OVERFLOW_EN
    ,
    output logic         ov
`endif
);

    localparam int               CNT_W    = bsa_cnt_width(N);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    bsa_state_e       state_q, state_d;
    logic [N-1:0]     xs_q, xs_d;
    logic [N-1:0]     ys_q, ys_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]     r_q, r_d;
    logic             co_q, co_d;

    logic             fa_s;
    logic             fa_co;
    logic [N-1:0]     ss_shift;
    logic             run_en;

    fa u_fa (
        .co (fa_co),
        .s  (fa_s),
        .ci (carry_q),
        .x  (xs_q[0]),
        .y  (ys_q[0])
    );

    assign run_en = (state_q == BSA_RUN);

    // Sum bits enter at the MSB; only the upper N-1 bits need storage since
    // the newest bit comes straight from the full adder.
    generate
        if (N == 1) begin : g_sum_n1
            assign ss_shift = fa_s;
        end else begin : g_sum_nx
            logic [N-2:0] ss_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ss_q <= '0;
                end else if (run_en) begin
                    ss_q <= ss_shift[N-1:1];
                end
            end

            assign ss_shift = {fa_s, ss_q};
        end
    endgenerate

`ifdef BSA_OVERFLOW_EN
    logic ov_q, ov_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BSA_IDLE;
            xs_q    <= '0;
            ys_q    <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            r_q     <= '0;
            co_q    <= 1'b0;
`ifdef BSA_OVERFLOW_EN
            ov_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            xs_q    <= xs_d;
            ys_q    <= ys_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            co_q    <= co_d;
`ifdef BSA_OVERFLOW_EN
            ov_q    <= ov_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        xs_d    = xs_q;
        ys_d    = ys_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        co_d    = co_q;
`ifdef BSA_OVERFLOW_EN
        ov_d    = ov_q;
`endif

        case (state_q)
            BSA_IDLE, BSA_DONE: begin
                if (start) begin
                    xs_d    = x;
                    ys_d    = y;
                    carry_d = ci;
                    cnt_d   = '0;
                    state_d = BSA_RUN;
                end else begin
                    state_d = BSA_IDLE;
                end
            end

            BSA_RUN: begin
                xs_d    = xs_q >> 1;
                ys_d    = ys_q >> 1;
                carry_d = fa_co;
                cnt_d   = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    r_d     = ss_shift;
                    co_d    = fa_co;
`ifdef BSA_OVERFLOW_EN
                    // carry_q is the carry into the MSB on this final cycle
                    ov_d    = carry_q ^ fa_co;
`endif
                    state_d = BSA_DONE;
                end
            end

            default: begin
                state_d = BSA_IDLE;
            end
        endcase
    end

    assign r    = r_q;
    assign co   = co_q;
    assign busy = (state_q == BSA_RUN);
    assign done = (state_q == BSA_DONE);
`ifdef BSA_OVERFLOW_EN
    assign ov   = ov_q;
`endif

endmodule : bit_serial_adder
`default_nettype wire

// File: tb/tb_bit_serial_adder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_bit_serial_adder                                            |
// | Brief   : Directed self-checking bench for bit_serial_adder (N=8, N=1).  |
// | Rev     : 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_bit_serial_adder;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] x;
    logic [7:0] y;
    logic       ci;
    logic [7:0] r;
    logic       co;
    logic       busy;
    logic       done;

    logic       start1;
    logic [0:0] x1;
    logic [0:0] y1;
    logic       ci1;
    logic [0:0] r1;
    logic       co1;
    logic       busy1;
    logic       done1;

`ifdef BSA_OVERFLOW_EN
    logic       ov;
    logic       ov1;
`endif

    int tests = 0;
    int fails = 0;

    bit_serial_adder #(.N(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .x     (x),
        .y     (y),
        .ci    (ci),
        .r     (r),
        .co    (co),
        .busy  (busy),
        .done  (done)
`ifdef BSA_OVERFLOW_EN
        ,
        .ov    (ov)
`endif
    );

    bit_serial_adder #(.N(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start1),
        .x     (x1),
        .y     (y1),
        .ci    (ci1),
        .r     (r1),
        .co    (co1),
        .busy  (busy1),
        .done  (done1)
`ifdef BSA_OVERFLOW_EN
        ,
        .ov    (ov1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
    endtask

    // Issue one add on the N=8 instance and check handshake timing and result
    task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic c, input logic [7:0] er, input logic eco);
        int lat;
        x     = a;
        y     = b;
        ci    = c;
        start = 1'b1;
        step();
        start = 1'b0;
        check({tag, " busy"}, busy, 1);
        wait_done(lat);
        check({tag, " latency"}, lat, 8);
        check({tag, " r"}, r, er);
        check({tag, " co"}, co, eco);
        check({tag, " busy@done"}, busy, 0);
        step();
        check({tag, " done pulse"}, done, 0);
    endtask

    initial begin
        int lat;
        int seen;

        rst_n  = 1'b0;
        start  = 1'b0;
        x      = '0;
        y      = '0;
        ci     = 1'b0;
        start1 = 1'b0;
        x1     = '0;
        y1     = '0;
        ci1    = 1'b0;

        // Reset state
        step();
        step();
        check("rst r", r, 0);
        check("rst co", co, 0);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
`ifdef BSA_OVERFLOW_EN
        check("rst ov", ov, 0);
`endif
        rst_n = 1'b1;
        step();

        // Basic adds and carry boundaries
        run8("t1", 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0);
`ifdef BSA_OVERFLOW_EN
        check("t1 ov", ov, 0);
`endif
        step();
        step();
        step();
        check("t1 hold r", r, 8'h7F);

        run8("t2a", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
`ifdef BSA_OVERFLOW_EN
        check("t2a ov", ov, 0);
`endif
        run8("t2b", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
`ifdef BSA_OVERFLOW_EN
        check("t2b ov", ov, 0);
`endif

        // Signed overflow cases (r/co checked in every build)
        run8("t3a", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0);
`ifdef BSA_OVERFLOW_EN
        check("t3a ov", ov, 1);
`endif
        run8("t3b", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1);
`ifdef BSA_OVERFLOW_EN
        check("t3b ov", ov, 1);
`endif

        // start while busy is ignored
        x     = 8'h12;
        y     = 8'h34;
        ci    = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        x     = 8'hAA;
        y     = 8'h55;
        ci    = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        check("t4 busy kept", busy, 1);
        lat = 3;
        while (done !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
        check("t4 ignore latency", lat, 8);
        check("t4 ignore r", r, 8'h46);
        check("t4 ignore co", co, 0);
        step();

        // start held high through done: back-to-back add
        x     = 8'h0F;
        y     = 8'hF0;
        ci    = 1'b0;
        start = 1'b1;
        step();
        x     = 8'h21;
        y     = 8'h43;
        ci    = 1'b1;
        wait_done(lat);
        check("t4b first latency", lat, 8);
        check("t4b first r", r, 8'hFF);
        check("t4b first co", co, 0);
        step();
        start = 1'b0;
        check("t4b rerun busy", busy, 1);
        check("t4b rerun done", done, 0);
        wait_done(lat);
        check("t4b second gap", lat + 1, 9);
        check("t4b second r", r, 8'h65);
        check("t4b second co", co, 0);
        step();

        // Asynchronous reset in the middle of an add
        x     = 8'h11;
        y     = 8'h22;
        ci    = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        check("t5 busy pre", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5 rst busy", busy, 0);
        check("t5 rst done", done, 0);
        check("t5 rst r", r, 0);
        check("t5 rst co", co, 0);
        #1;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done === 1'b1) seen++;
        end
        check("t5 no done after abort", seen, 0);
        check("t5 r after abort", r, 0);

        // N=1 instance
        x1     = 1'b1;
        y1     = 1'b1;
        ci1    = 1'b1;
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        check("t6a busy", busy1, 1);
        lat = 0;
        while (done1 !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
        check("t6a latency", lat, 1);
        check("t6a r", r1, 1);
        check("t6a co", co1, 1);
        step();
        check("t6a done pulse", done1, 0);

        x1     = 1'b1;
        y1     = 1'b0;
        ci1    = 1'b0;
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        lat = 0;
        while (done1 !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
        check("t6b latency", lat, 1);
        check("t6b r", r1, 1);
        check("t6b co", co1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_bit_serial_adder
`default_nettype wire
